div_unit: RTL

- Multi-cycle 32-bit integer divider for the DIV/DIVU instructions.
- Sits in the execute stage, directly upstream of the HI/LO register file. The {remainder, quotient} it produces travels down the pipeline and is written as HI = remainder, LO = quotient.
- Uses radix-2 restoring division: one quotient bit per cycle, with a start/ready handshake to the EX stall logic and an annul input for pipeline flush.

---
 rtl/div_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, with a
// start/ready handshake to the EX stall logic and an annul input for flushes.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W:0]     r_work;
    logic [DATA_W-1:0]     r_divisor;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic [DATA_W-1:0]     w_abs_a;
    logic [DATA_W-1:0]     w_abs_b;
    logic [DATA_W:0]       w_diff;
    logic [DATA_W-1:0]     w_quot;
    logic [DATA_W-1:0]     w_rem;
    logic                  w_go;
    logic                  w_last;

    assign w_go    = start_i && !annul_i;
    assign w_last  = (r_cnt == CNT_W'(DATA_W));
    assign w_abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // The partial remainder always stays below the divisor, so the low DATA_W
    // bits of a non-negative difference hold it exactly.
    assign w_diff  = r_work[2*DATA_W:DATA_W] - {1'b0, r_divisor};
    assign w_quot  = r_work[DATA_W-1:0];
    assign w_rem   = r_work[2*DATA_W:DATA_W+1];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FREE:   if (w_go) w_next_state = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
            ST_BYZERO: w_next_state = annul_i ? ST_FREE : ST_END;
            ST_ON:     if (annul_i) w_next_state = ST_FREE;
                       else if (w_last) w_next_state = ST_END;
            ST_END:    if (annul_i || !start_i) w_next_state = ST_FREE;
            default:   w_next_state = ST_FREE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FREE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_FREE: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (w_go && opdata2_i != '0) begin
                        r_work    <= {{DATA_W{1'b0}}, w_abs_a, 1'b0};
                        r_divisor <= w_abs_b;
                        r_neg_q   <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        r_neg_r   <= signed_div_i && opdata1_i[DATA_W-1];
                        r_cnt     <= '0;
                    end
                end
                ST_BYZERO: begin
                    r_result <= '0;
                    r_ready  <= !annul_i;
                end
                ST_ON: begin
                    if (annul_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else if (!w_last) begin
                        if (w_diff[DATA_W]) begin
                            r_work <= {r_work[2*DATA_W-1:0], 1'b0};
                        end else begin
                            r_work <= {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_result <= {r_neg_r ? -w_rem : w_rem, r_neg_q ? -w_quot : w_quot};
                        r_ready  <= 1'b1;
                    end
                end
                ST_END: begin
                    if (annul_i || !start_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
